// File: rtl/rv32_mem_access.sv
// RV32 memory-access stage: issues one bus transfer per load/store, resolves branches,
// and registers the writeback controls for the next stage.
module rv32_mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic        alu_non_zero_in,
  input  logic        branch_predicted_taken_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_fence_in,
  input  logic        mem_zero_extend_in,
  input  logic [1:0]  mem_width_in,
  input  logic [1:0]  branch_op_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in,
  output logic        busy_out,
  output logic        branch_taken_out,
  output logic        branch_mispredicted_out,
  output logic        valid_out,
  output logic        rd_write_out,
  output logic [4:0]  rd_out,
  output logic [31:0] rd_value_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] BR_NEVER    = 2'd0;
  localparam logic [1:0] BR_ZERO     = 2'd1;
  localparam logic [1:0] BR_NON_ZERO = 2'd2;
  localparam logic [1:0] BR_ALWAYS   = 2'd3;

  state_t      state_reg, state_next;

  // Operation captured at issue, held for the whole transfer
  logic [31:0] op_addr_reg;
  logic [3:0]  op_mask_reg;
  logic [31:0] op_wval_reg;
  logic [1:0]  op_width_reg;
  logic        op_zext_reg;
  logic [1:0]  op_lo_reg;
  logic        op_write_reg;
  logic [4:0]  op_rd_reg;
  logic        op_rd_write_reg;
  logic [31:0] op_result_reg;
  logic        op_flushed_reg;
  logic [31:0] load_buf_reg;

  // Writeback output registers
  logic        wb_valid_reg;
  logic        wb_rd_write_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_value_reg;

  logic        issue;
  logic        wb_kill;
  logic [3:0]  mask_calc;
  logic [31:0] wval_calc;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  // A fence never takes a bus cycle, even if the decoder also flags a read/write.
  assign issue = (state_reg == IDLE) && valid_in && (mem_read_in || mem_write_in)
                 && !mem_fence_in && !flush_in;

  // Per-lane store mask and replicated store data; widths 2 and 3 are both word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign mask_calc[gi] = (mem_width_in == 2'd0) ? (result_in[1:0] == LANE) :
                             (mem_width_in == 2'd1) ? (result_in[1] == LANE[1]) :
                                                      1'b1;
      assign wval_calc[8*gi +: 8] = (mem_width_in == 2'd0) ? rs2_value_in[7:0] :
                                    (mem_width_in == 2'd1) ? rs2_value_in[8*(gi%2) +: 8] :
                                                             rs2_value_in[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_byte  = bus_read_value_in[7:0];
    load_half  = bus_read_value_in[15:0];
    load_value = bus_read_value_in;
    case (op_lo_reg)
      2'd0:    load_byte = bus_read_value_in[7:0];
      2'd1:    load_byte = bus_read_value_in[15:8];
      2'd2:    load_byte = bus_read_value_in[23:16];
      default: load_byte = bus_read_value_in[31:24];
    endcase
    if (op_lo_reg[1]) begin
      load_half = bus_read_value_in[31:16];
    end
    case (op_width_reg)
      2'd0:    load_value = {{24{load_byte[7] & ~op_zext_reg}}, load_byte};
      2'd1:    load_value = {{16{load_half[15] & ~op_zext_reg}}, load_half};
      default: load_value = bus_read_value_in;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    busy_out      = 1'b0;
    bus_read_out  = 1'b0;
    bus_write_out = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_out = issue;
        if (issue) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy_out      = 1'b1;
        bus_read_out  = !op_write_reg;
        bus_write_out = op_write_reg;
        if (bus_ready_in) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!stall_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outside ACCESS the bus fields just track the current instruction.
  assign bus_address_out     = (state_reg == ACCESS) ? op_addr_reg : {result_in[31:2], 2'b00};
  assign bus_write_mask_out  = (state_reg == ACCESS) ? op_mask_reg : mask_calc;
  assign bus_write_value_out = (state_reg == ACCESS) ? op_wval_reg : wval_calc;

  always_comb begin
    branch_taken_out = 1'b0;
    case (branch_op_in)
      BR_NEVER:    branch_taken_out = 1'b0;
      BR_ZERO:     branch_taken_out = !alu_non_zero_in;
      BR_NON_ZERO: branch_taken_out = alu_non_zero_in;
      BR_ALWAYS:   branch_taken_out = 1'b1;
      default:     branch_taken_out = 1'b0;
    endcase
  end

  assign branch_mispredicted_out = (state_reg == IDLE) && valid_in
                                   && (branch_taken_out != branch_predicted_taken_in);

  // A flush seen at any point after issue squashes the in-flight op at writeback.
  assign wb_kill = flush_in || op_flushed_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      op_addr_reg     <= 32'd0;
      op_mask_reg     <= 4'd0;
      op_wval_reg     <= 32'd0;
      op_width_reg    <= 2'd0;
      op_zext_reg     <= 1'b0;
      op_lo_reg       <= 2'd0;
      op_write_reg    <= 1'b0;
      op_rd_reg       <= 5'd0;
      op_rd_write_reg <= 1'b0;
      op_result_reg   <= 32'd0;
      op_flushed_reg  <= 1'b0;
      load_buf_reg    <= 32'd0;
      wb_valid_reg    <= 1'b0;
      wb_rd_write_reg <= 1'b0;
      wb_rd_reg       <= 5'd0;
      wb_value_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;

      if (issue) begin
        op_addr_reg     <= {result_in[31:2], 2'b00};
        op_mask_reg     <= mask_calc;
        op_wval_reg     <= wval_calc;
        op_width_reg    <= mem_width_in;
        op_zext_reg     <= mem_zero_extend_in;
        op_lo_reg       <= result_in[1:0];
        op_write_reg    <= mem_write_in;
        op_rd_reg       <= rd_in;
        op_rd_write_reg <= rd_write_in;
        op_result_reg   <= result_in;
        op_flushed_reg  <= 1'b0;
      end else if ((state_reg != IDLE) && flush_in) begin
        op_flushed_reg <= 1'b1;
      end

      if ((state_reg == ACCESS) && bus_ready_in) begin
        load_buf_reg <= op_write_reg ? op_result_reg : load_value;
      end

      if ((state_reg == DONE) && !stall_in) begin
        wb_valid_reg    <= !wb_kill;
        wb_rd_write_reg <= op_rd_write_reg && !wb_kill;
        wb_rd_reg       <= op_rd_reg;
        wb_value_reg    <= load_buf_reg;
      end else if ((state_reg == IDLE) && !issue && !stall_in) begin
        wb_valid_reg    <= valid_in && !flush_in;
        wb_rd_write_reg <= valid_in && rd_write_in && !flush_in;
        wb_rd_reg       <= rd_in;
        wb_value_reg    <= result_in;
      end
    end
  end

  assign valid_out    = wb_valid_reg;
  assign rd_write_out = wb_rd_write_reg;
  assign rd_out       = wb_rd_reg;
  assign rd_value_out = wb_value_reg;

endmodule

// File: tb/tb_rv32_mem_access.sv
// Directed bench for rv32_mem_access: loads/stores of every width, branches,
// stall/flush handling and asynchronous reset mid-transfer.
module tb_rv32_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in, flush_in, valid_in, alu_non_zero_in, branch_predicted_taken_in;
  logic        mem_read_in, mem_write_in, mem_fence_in, mem_zero_extend_in;
  logic [1:0]  mem_width_in, branch_op_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic [31:0] result_in, rs2_value_in;
  logic [31:0] bus_address_out;
  logic        bus_read_out, bus_write_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;
  logic        busy_out, branch_taken_out, branch_mispredicted_out;
  logic        valid_out, rd_write_out;
  logic [4:0]  rd_out;
  logic [31:0] rd_value_out;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rv32_mem_access dut (
    .clk                       (clk),
    .reset                     (reset),
    .stall_in                  (stall_in),
    .flush_in                  (flush_in),
    .valid_in                  (valid_in),
    .alu_non_zero_in           (alu_non_zero_in),
    .branch_predicted_taken_in (branch_predicted_taken_in),
    .mem_read_in               (mem_read_in),
    .mem_write_in              (mem_write_in),
    .mem_fence_in              (mem_fence_in),
    .mem_zero_extend_in        (mem_zero_extend_in),
    .mem_width_in              (mem_width_in),
    .branch_op_in              (branch_op_in),
    .rd_in                     (rd_in),
    .rd_write_in               (rd_write_in),
    .result_in                 (result_in),
    .rs2_value_in              (rs2_value_in),
    .bus_address_out           (bus_address_out),
    .bus_read_out              (bus_read_out),
    .bus_write_out             (bus_write_out),
    .bus_write_mask_out        (bus_write_mask_out),
    .bus_write_value_out       (bus_write_value_out),
    .bus_read_value_in         (bus_read_value_in),
    .bus_ready_in              (bus_ready_in),
    .busy_out                  (busy_out),
    .branch_taken_out          (branch_taken_out),
    .branch_mispredicted_out   (branch_mispredicted_out),
    .valid_out                 (valid_out),
    .rd_write_out              (rd_write_out),
    .rd_out                    (rd_out),
    .rd_value_out              (rd_value_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
    alu_non_zero_in = 1'b0; branch_predicted_taken_in = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_fence_in = 1'b0;
    mem_zero_extend_in = 1'b0; mem_width_in = 2'd0; branch_op_in = 2'd0;
    rd_in = 5'd0; rd_write_in = 1'b0; result_in = 32'd0; rs2_value_in = 32'd0;
    bus_read_value_in = 32'd0; bus_ready_in = 1'b0;
  endtask

  // One load/store from issue to writeback; called one time unit after a rising edge, in IDLE.
  task automatic mem_op(input string name, input logic wr, input logic [1:0] width,
                        input logic zext, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rdw, input int waits,
                        input logic [31:0] rdata, input int done_stall, input logic flush_acc,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wval, input logic [31:0] exp_value,
                        input logic exp_valid, input int exp_busy);
    int          busy_cnt;
    logic        prev_valid;
    logic [31:0] prev_value;
    valid_in = 1'b1; mem_read_in = ~wr; mem_write_in = wr; mem_width_in = width;
    mem_zero_extend_in = zext; result_in = addr; rs2_value_in = rs2; rd_in = rd;
    rd_write_in = rdw; branch_op_in = 2'd3; branch_predicted_taken_in = 1'b0;
    stall_in = 1'b1;
    #1;
    busy_cnt   = int'(busy_out);
    prev_valid = valid_out;
    prev_value = rd_value_out;
    check_eq({name, "_issue_mispred"}, 32'(branch_mispredicted_out), 32'd1);
    check_eq({name, "_issue_rw"}, 32'({bus_read_out, bus_write_out}), 32'd0);
    step;
    for (int w = 0; w <= waits; w++) begin
      if (w == waits) begin
        bus_ready_in = 1'b1;
        bus_read_value_in = rdata;
      end
      flush_in = flush_acc;
      #1;
      busy_cnt += int'(busy_out);
      check_eq({name, "_bus_addr"}, bus_address_out, exp_addr);
      check_eq({name, "_bus_rw"}, 32'({bus_read_out, bus_write_out}), 32'({~wr, wr}));
      if (wr) begin
        check_eq({name, "_mask"}, 32'(bus_write_mask_out), 32'(exp_mask));
        check_eq({name, "_wval"}, bus_write_value_out, exp_wval);
      end
      check_eq({name, "_access_mispred"}, 32'(branch_mispredicted_out), 32'd0);
      check_eq({name, "_access_hold"}, 32'(valid_out), 32'(prev_valid));
      step;
      bus_ready_in = 1'b0; flush_in = 1'b0; bus_read_value_in = 32'd0;
    end
    for (int s = 0; s < done_stall; s++) begin
      stall_in = 1'b1;
      #1;
      busy_cnt += int'(busy_out);
      check_eq({name, "_stall_rw"}, 32'({bus_read_out, bus_write_out}), 32'd0);
      check_eq({name, "_stall_value"}, rd_value_out, prev_value);
      check_eq({name, "_stall_valid"}, 32'(valid_out), 32'(prev_valid));
      step;
    end
    stall_in = 1'b0;
    #1;
    busy_cnt += int'(busy_out);
    check_eq({name, "_done_rw"}, 32'({bus_read_out, bus_write_out}), 32'd0);
    step;
    clear_inputs;
    #1;
    check_eq({name, "_valid"}, 32'(valid_out), 32'(exp_valid));
    check_eq({name, "_rd_write"}, 32'(rd_write_out), 32'(exp_valid & rdw));
    check_eq({name, "_rd"}, 32'(rd_out), 32'(rd));
    check_eq({name, "_value"}, rd_value_out, exp_value);
    check_eq({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check_eq({name, "_after_rw"}, 32'({bus_read_out, bus_write_out}), 32'd0);
    $display("[TB] %s: rd=%0d value=0x%08h valid=%0b busy_cycles=%0d",
             name, rd_out, rd_value_out, valid_out, busy_cnt);
  endtask

  // Branch vectors: valid, op, alu_non_zero, predicted, expected taken, expected mispredicted
  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic       nz;
    logic       pred;
    logic       taken;
    logic       mis;
  } br_vec_t;

  br_vec_t br_vecs[7] = '{
    '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0},
    '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0},
    '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1},
    '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1},
    '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1},
    '{1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    clear_inputs;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_valid", 32'(valid_out), 32'd0);
    check_eq("reset_value", rd_value_out, 32'd0);
    check_eq("reset_rw", 32'({bus_read_out, bus_write_out}), 32'd0);
    check_eq("reset_busy", 32'(busy_out), 32'd0);
    reset = 1'b0;
    step;

    // Plain ALU op: passes straight into the writeback registers
    valid_in = 1'b1; rd_in = 5'd7; rd_write_in = 1'b1; result_in = 32'h0000_1237;
    #1;
    check_eq("alu_busy", 32'(busy_out), 32'd0);
    check_eq("alu_idle_addr", bus_address_out, 32'h0000_1234);
    step;
    clear_inputs;
    #1;
    check_eq("alu_valid", 32'(valid_out), 32'd1);
    check_eq("alu_rd", 32'(rd_out), 32'd7);
    check_eq("alu_value", rd_value_out, 32'h0000_1237);
    $display("[TB] alu: rd=%0d value=0x%08h", rd_out, rd_value_out);

    // Stalled ALU op holds the previous writeback
    valid_in = 1'b1; rd_in = 5'd9; rd_write_in = 1'b1; result_in = 32'h0000_5555; stall_in = 1'b1;
    step;
    check_eq("alu_stall_value", rd_value_out, 32'h0000_1237);
    check_eq("alu_stall_rd", 32'(rd_out), 32'd7);
    stall_in = 1'b0;
    step;
    check_eq("alu_unstall_value", rd_value_out, 32'h0000_5555);
    $display("[TB] alu stall: rd=%0d value=0x%08h", rd_out, rd_value_out);

    // Flushed ALU op
    rd_in = 5'd10; result_in = 32'h0000_0077; flush_in = 1'b1;
    step;
    clear_inputs;
    #1;
    check_eq("alu_flush_valid", 32'(valid_out), 32'd0);
    check_eq("alu_flush_rd_write", 32'(rd_write_out), 32'd0);
    $display("[TB] alu flush: valid=%0b rd_write=%0b", valid_out, rd_write_out);

    // Fence completes in IDLE without a bus cycle
    valid_in = 1'b1; mem_fence_in = 1'b1; rd_in = 5'd3; rd_write_in = 1'b1; result_in = 32'h0000_ABCD;
    #1;
    check_eq("fence_busy", 32'(busy_out), 32'd0);
    step;
    clear_inputs;
    #1;
    check_eq("fence_rw", 32'({bus_read_out, bus_write_out}), 32'd0);
    check_eq("fence_valid", 32'(valid_out), 32'd1);
    check_eq("fence_value", rd_value_out, 32'h0000_ABCD);
    $display("[TB] fence: value=0x%08h", rd_value_out);

    // Branch resolution, combinational in IDLE
    foreach (br_vecs[i]) begin
      valid_in = br_vecs[i].valid; branch_op_in = br_vecs[i].op;
      alu_non_zero_in = br_vecs[i].nz; branch_predicted_taken_in = br_vecs[i].pred;
      #1;
      check_eq($sformatf("br%0d_taken", i), 32'(branch_taken_out), 32'(br_vecs[i].taken));
      check_eq($sformatf("br%0d_mispred", i), 32'(branch_mispredicted_out), 32'(br_vecs[i].mis));
      $display("[TB] branch %0d: op=%0d taken=%0b mispred=%0b", i, branch_op_in,
               branch_taken_out, branch_mispredicted_out);
    end
    clear_inputs;
    step;

    //     name          wr    w     z     addr          rs2           rd     rdw   wt rdata         st fl    exp_addr      mask     wval          value         v     busy
    mem_op("lb_sign",    1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,       5'd5,  1'b1, 2, 32'h8012_3456, 0, 1'b0, 32'h0000_1000, 4'h0,    32'h0,        32'hFFFF_FF80, 1'b1, 4);
    mem_op("sh",         1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 5'd6, 1'b1, 0, 32'h0,       0, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2002, 1'b1, 2);
    mem_op("lhu",        1'b0, 2'd1, 1'b1, 32'h0000_3002, 32'h0,       5'd8,  1'b1, 1, 32'h8001_1234, 0, 1'b0, 32'h0000_3000, 4'h0,    32'h0,        32'h0000_8001, 1'b1, 3);
    mem_op("lh_sign",    1'b0, 2'd1, 1'b0, 32'h0000_3000, 32'h0,       5'd9,  1'b1, 0, 32'h1234_9ABC, 0, 1'b0, 32'h0000_3000, 4'h0,    32'h0,        32'hFFFF_9ABC, 1'b1, 2);
    mem_op("lbu",        1'b0, 2'd0, 1'b1, 32'h0000_4001, 32'h0,       5'd11, 1'b1, 0, 32'h1122_C344, 0, 1'b0, 32'h0000_4000, 4'h0,    32'h0,        32'h0000_00C3, 1'b1, 2);
    mem_op("lw_w3",      1'b0, 2'd3, 1'b0, 32'h0000_0104, 32'h0,       5'd12, 1'b1, 0, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0104, 4'h0,    32'h0,        32'hDEAD_BEEF, 1'b1, 2);
    mem_op("sb",         1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h1122_3344, 5'd13, 1'b0, 0, 32'h0,      0, 1'b0, 32'h0000_0004, 4'b0010, 32'h4444_4444, 32'h0000_0005, 1'b1, 2);
    mem_op("sw",         1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 5'd14, 1'b1, 1, 32'h0,      0, 1'b0, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0000_0008, 1'b1, 3);
    mem_op("lb_done_st", 1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0,       5'd15, 1'b1, 0, 32'h1234_567F, 3, 1'b0, 32'h0000_0010, 4'h0,    32'h0,        32'h0000_007F, 1'b1, 2);
    mem_op("lw_flush",   1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,       5'd16, 1'b1, 1, 32'h5555_AAAA, 0, 1'b1, 32'h0000_0020, 4'h0,    32'h0,        32'h5555_AAAA, 1'b0, 3);

    // Make valid_out high, then reset in the middle of a load
    valid_in = 1'b1; rd_in = 5'd1; rd_write_in = 1'b1; result_in = 32'h0000_0042;
    step;
    check_eq("pre_reset_valid", 32'(valid_out), 32'd1);
    mem_read_in = 1'b1; result_in = 32'h0000_0040; stall_in = 1'b1;
    step;
    check_eq("pre_reset_read", 32'(bus_read_out), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("reset_access_read", 32'(bus_read_out), 32'd0);
    check_eq("reset_access_valid", 32'(valid_out), 32'd0);
    check_eq("reset_access_value", rd_value_out, 32'd0);
    clear_inputs;
    step;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step;
      check_eq($sformatf("post_reset_rw%0d", c), 32'({bus_read_out, bus_write_out}), 32'd0);
      check_eq($sformatf("post_reset_busy%0d", c), 32'(busy_out), 32'd0);
    end
    $display("[TB] reset mid-access: read=%0b valid=%0b", bus_read_out, valid_out);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
